// File: rtl/mem_arbiter.sv
// Shares one single-port registered-read RAM between instruction fetch and load/store.
// Latency: grant edge -> ACCESS -> READ -> ready pulse; one access every 4 cycles.
// Backpressure: requesters hold req until their ready pulse; requests sampled only in IDLE.
//
// Ports: clock/reset (async active-high); fetch_req/addr -> fetch_ready/rdata;
//        data_req/we/addr/wdata -> data_ready/rdata; ram_address/data/wren/q to the RAM;
//        busy is high whenever an access is in flight.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
//               simultaneous requests; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_ready,
    output logic [DW-1:0] fetch_rdata,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_ready,
    output logic [DW-1:0] data_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] READ   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic       cur_is_data;   // port id of the access in flight
    logic       cur_we;        // latched write enable (fetch is always a read)
    logic       grant_data;    // winner if a grant happens this cycle
    logic       any_req;

    assign any_req = fetch_req | data_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // favour_data = 1 means fetch was granted last (or nothing yet since reset),
    // so data wins the next tie.
    logic favour_data;

    assign grant_data = data_req & (~fetch_req | favour_data);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            favour_data <= 1'b1;
        end else if (state == IDLE && any_req) begin
            favour_data <= ~grant_data;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_is_data <= 1'b0;
            cur_we      <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ACCESS;
                        cur_is_data <= grant_data;
                        cur_we      <= grant_data & data_we;
                        ram_address <= grant_data ? data_addr : fetch_addr;
                        // Fetch never writes, so the RAM data bus keeps its last store value.
                        if (grant_data) begin
                            ram_data <= data_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state <= READ;
                end
                READ: begin
                    // ram_q reflects the address sampled at the end of ACCESS.
                    if (!cur_we) begin
                        if (cur_is_data) begin
                            data_rdata <= ram_q;
                        end else begin
                            fetch_rdata <= ram_q;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an asynchronous reset clears them at once; a reset
    // during ACCESS therefore drops the store before the RAM samples it.
    assign ram_wren    = (state == ACCESS) & cur_we;
    assign fetch_ready = (state == DONE) & ~cur_is_data;
    assign data_ready  = (state == DONE) & cur_is_data;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ready;
    logic [15:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_ready;
    logic [15:0] data_rdata;
    logic [15:0] ram_address;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic [15:0] ram_q;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ready  (data_ready),
        .data_rdata  (data_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port RAM with registered read and a side preload port.
    logic [15:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_dat;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        else if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Issues one data-port access from an IDLE negedge and returns the number of
    // cycles until data_ready (0 if it never came); ends at the following IDLE negedge.
    task automatic run_data(input logic we, input logic [15:0] a, input logic [15:0] d,
                            output int lat);
        lat = 0;
        data_req = 1'b1; data_we = we; data_addr = a; data_wdata = d;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (data_ready) begin
                lat = i;
                break;
            end
        end
        data_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
        checks++; if (ram_address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", ram_address); end
        checks++; if (ram_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", ram_data); end
        checks++; if ({fetch_ready, data_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {fetch_ready, data_ready}); end
        checks++; if (fetch_rdata !== 16'h0000) begin errors++; $display("FAIL reset_frdata: got %h want 0000", fetch_rdata); end
        checks++; if (data_rdata !== 16'h0000) begin errors++; $display("FAIL reset_drdata: got %h want 0000", data_rdata); end
        @(negedge clock);
        reset = 1'b0;
        preload(16'h0010, 16'h1111);
        preload(16'h0008, 16'hCAFE);
        preload(16'h0000, 16'h1234);
    endtask

    task automatic test_store_load;
        int lat;
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0002; data_wdata = 16'hBEEF;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL st_k_wren: got %b want 0", ram_wren); end
        @(negedge clock); // k+1 ACCESS
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL st_k1_wren: got %b want 1", ram_wren); end
        checks++; if (ram_address !== 16'h0002) begin errors++; $display("FAIL st_k1_addr: got %h want 0002", ram_address); end
        checks++; if (ram_data !== 16'hBEEF) begin errors++; $display("FAIL st_k1_data: got %h want beef", ram_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL st_k1_busy: got %b want 1", busy); end
        @(negedge clock); // k+2 READ
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL st_k2_wren: got %b want 0", ram_wren); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL st_k2_ready: got %b want 0", data_ready); end
        @(negedge clock); // k+3 DONE
        checks++; if ({data_ready, fetch_ready} !== 2'b10) begin errors++; $display("FAIL st_k3_ready: got %b want 10", {data_ready, fetch_ready}); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL st_k3_wren: got %b want 0", ram_wren); end
        data_req = 1'b0;
        @(negedge clock); // k+4 IDLE
        checks++; if ({busy, data_ready} !== 2'b00) begin errors++; $display("FAIL st_k4_idle: got %b want 00", {busy, data_ready}); end
        checks++; if (mem[2] !== 16'hBEEF) begin errors++; $display("FAIL st_mem: got %h want beef", mem[2]); end
        run_data(1'b0, 16'h0002, 16'h0000, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency: got %0d want 3", lat); end
        checks++; if (data_rdata !== 16'hBEEF) begin errors++; $display("FAIL ld_rdata: got %h want beef", data_rdata); end
        checks++; if (fetch_rdata !== 16'h0000) begin errors++; $display("FAIL ld_frdata: got %h want 0000", fetch_rdata); end
    endtask

    task automatic test_fetch_read;
        int rdy_cyc = 0;
        logic wren_seen = 1'b0;
        logic dready_seen = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (ram_wren) wren_seen = 1'b1;
            if (data_ready) dready_seen = 1'b1;
            if (fetch_ready && rdy_cyc == 0) begin
                rdy_cyc = i;
                fetch_req = 1'b0;
            end
        end
        fetch_req = 1'b0;
        checks++; if (rdy_cyc !== 3) begin errors++; $display("FAIL fetch_latency: got %0d want 3", rdy_cyc); end
        checks++; if (fetch_rdata !== 16'h1234) begin errors++; $display("FAIL fetch_rdata: got %h want 1234", fetch_rdata); end
        checks++; if (wren_seen !== 1'b0) begin errors++; $display("FAIL fetch_wren: got %b want 0", wren_seen); end
        checks++; if (dready_seen !== 1'b0) begin errors++; $display("FAIL fetch_dready: got %b want 0", dready_seen); end
        checks++; if (data_rdata !== 16'hBEEF) begin errors++; $display("FAIL fetch_drdata_kept: got %h want beef", data_rdata); end
    endtask

    task automatic test_reset_mid_access;
        logic dready_seen = 1'b0;
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0010; data_wdata = 16'h5A5A;
        @(negedge clock); // ACCESS
        checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL rst_pre_wren: got %b want 1", ram_wren); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fetch_rdata !== 16'h0000) begin errors++; $display("FAIL rst_frdata: got %h want 0000", fetch_rdata); end
        checks++; if (data_rdata !== 16'h0000) begin errors++; $display("FAIL rst_drdata: got %h want 0000", data_rdata); end
        checks++; if (ram_address !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", ram_address); end
        @(negedge clock);
        reset = 1'b0;
        data_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (data_ready) dready_seen = 1'b1;
        end
        checks++; if (dready_seen !== 1'b0) begin errors++; $display("FAIL rst_no_ready: got %b want 0", dready_seen); end
        checks++; if (mem[16] !== 16'h1111) begin errors++; $display("FAIL rst_store_dropped: got %h want 1111", mem[16]); end
    endtask

    task automatic test_simultaneous;
        logic [3:0] seq = 4'b0000;
        logic [3:0] want;
        logic [15:0] want_f;
        int idx = 0;
        logic both_seen = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        want = 4'b0101;   // seq[0]=data, seq[1]=fetch, ...
        want_f = 16'h1234;
`else
        want = 4'b1111;
        want_f = 16'h0000;
`endif
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0002;
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (data_ready && fetch_ready) both_seen = 1'b1;
            if ((data_ready || fetch_ready) && idx < 4) begin
                seq[idx] = data_ready;
                idx++;
            end else if (data_ready || fetch_ready) begin
                idx++;
            end
        end
        data_req = 1'b0; fetch_req = 1'b0;
        @(negedge clock);
        checks++; if (idx !== 4) begin errors++; $display("FAIL sim_count: got %0d want 4", idx); end
        checks++; if (seq !== want) begin errors++; $display("FAIL sim_order: got %b want %b", seq, want); end
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL sim_both_ready: got %b want 0", both_seen); end
        checks++; if (data_rdata !== 16'hBEEF) begin errors++; $display("FAIL sim_drdata: got %h want beef", data_rdata); end
        checks++; if (fetch_rdata !== want_f) begin errors++; $display("FAIL sim_frdata: got %h want %h", fetch_rdata, want_f); end
    endtask

    task automatic test_addr_change;
        int lat;
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0004; data_wdata = 16'h7777;
        @(negedge clock); // ACCESS
        checks++; if (ram_address !== 16'h0004) begin errors++; $display("FAIL ac_access_addr: got %h want 0004", ram_address); end
        data_addr = 16'h0008; data_wdata = 16'h0BAD;
        @(negedge clock); // READ
        checks++; if (ram_address !== 16'h0004) begin errors++; $display("FAIL ac_held_addr: got %h want 0004", ram_address); end
        checks++; if (ram_data !== 16'h7777) begin errors++; $display("FAIL ac_held_data: got %h want 7777", ram_data); end
        @(negedge clock); // DONE
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL ac_ready: got %b want 1", data_ready); end
        data_req = 1'b0;
        @(negedge clock);
        run_data(1'b0, 16'h0004, 16'h0000, lat);
        checks++; if (data_rdata !== 16'h7777 || lat !== 3) begin errors++; $display("FAIL ac_read4: got %h/%0d want 7777/3", data_rdata, lat); end
        run_data(1'b0, 16'h0008, 16'h0000, lat);
        checks++; if (data_rdata !== 16'hCAFE) begin errors++; $display("FAIL ac_read8: got %h want cafe", data_rdata); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            checks++;
            if (fetch_ready !== ((i % 4) == 3)) begin
                errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", i, fetch_ready, (i % 4) == 3);
            end
            checks++;
            if (busy !== ((i % 4) != 0)) begin
                errors++; $display("FAIL b2b_busy_c%0d: got %b want %b", i, busy, (i % 4) != 0);
            end
            if (fetch_ready) pulses++;
        end
        fetch_req = 1'b0;
        @(negedge clock);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        checks++; if (fetch_rdata !== 16'h1234) begin errors++; $display("FAIL b2b_rdata: got %h want 1234", fetch_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy: got %b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        test_reset;
        test_store_load;
        test_fetch_read;
        test_reset_mid_access;
        test_simultaneous;
        test_addr_change;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
